// File: rtl/rr_grant_scheduler_pkg.sv
// Shared constants, FSM state type and one-hot decode helper for the
// round-robin grant scheduler.
package rr_sched_pkg;

    localparam int N_REQ = 16;
    localparam int IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_e;

    // The input is guaranteed one-hot, so OR-ing the indices of set bits
    // gives the encoded index without a priority chain.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_grant_scheduler_pick.sv
// Combinational wrap-around find-first: returns the first set request at or
// after i_ptr, wrapping from the top index back to 0.
module rr_pick
    import rr_sched_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_pick,
    output logic             o_any
);

    logic             w_found;
    logic [IDX_W-1:0] w_pos;

    // NOTE: every signal written here gets a default first, so no path
    // through the loop can leave one unassigned and infer a latch.
    always_comb begin
        o_pick  = '0;
        w_found = 1'b0;
        w_pos   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_pos = i_ptr + IDX_W'(k);
            if (!w_found && i_req[w_pos]) begin
                o_pick[w_pos] = 1'b1;
                w_found       = 1'b1;
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin scheduler: registered one-hot grant plus encoded index, bounded
// hold under contention, and a forced dead gap between successive grants.
module rr_grant_scheduler
    import rr_sched_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             preempt
);

    localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_e           r_state;
    logic [IDX_W-1:0] r_ptr;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [N_REQ-1:0] r_grant;
    logic [IDX_W-1:0] r_grant_idx;
    logic             r_grant_valid;
    logic             r_preempt;

    logic [N_REQ-1:0] w_pick;
    logic             w_any;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_release;
    logic             w_others;
    logic             w_hold_max;
    logic             w_expire;

    rr_pick u_pick (
        .i_req  (req),
        .i_ptr  (r_ptr),
        .o_pick (w_pick),
        .o_any  (w_any)
    );

    assign w_pick_idx = onehot_to_idx(w_pick);
    assign w_release  = ~|(req & r_grant);
    assign w_others   = |(req & ~r_grant);
    assign w_hold_max = (r_hold_cnt == HOLD_LAST);
    // Release wins over expiry, so preempt only fires while the owner still requests.
    assign w_expire   = w_hold_max && w_others && !w_release;

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_ptr         <= '0;
            r_hold_cnt    <= '0;
            r_grant       <= '0;
            r_grant_idx   <= '0;
            r_grant_valid <= 1'b0;
            r_preempt     <= 1'b0;
        end else begin
            r_preempt <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (en && w_any) begin
                        r_grant       <= w_pick;
                        r_grant_idx   <= w_pick_idx;
                        r_grant_valid <= 1'b1;
                        r_ptr         <= w_pick_idx + IDX_W'(1);
                        r_hold_cnt    <= '0;
                        r_state       <= GRANT;
                    end
                end
                GRANT: begin
                    if (!en || w_release || w_expire) begin
                        r_grant       <= '0;
                        r_grant_idx   <= '0;
                        r_grant_valid <= 1'b0;
                        r_hold_cnt    <= '0;
                        r_preempt     <= en && w_expire;
                        r_state       <= GAP;
                    end else if (!w_hold_max) begin
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    end
                end
                GAP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign grant       = r_grant;
    assign grant_idx   = r_grant_idx;
    assign grant_valid = r_grant_valid;
    assign preempt     = r_preempt;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Scoreboard bench for rr_grant_scheduler: a cycle-level reference model feeds
// an expectation queue that a separate monitor drains and compares.
module tb_rr_grant_scheduler;

    localparam int N  = 16;
    localparam int MH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] req;
    logic [15:0] grant;
    logic [3:0]  grant_idx;
    logic        grant_valid;
    logic        preempt;

    always #5 clk = ~clk;

    rr_grant_scheduler #(.MAX_HOLD(MH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .req         (req),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .preempt     (preempt)
    );

    typedef struct {
        logic [15:0] grant;
        logic [3:0]  idx;
        logic        valid;
        logic        pre;
    } exp_t;

    exp_t exp_q[$];
    int   seen_q[$];
    int   checks = 0;
    int   errors = 0;
    int   dut_pre_cnt = 0;
    bit   prev_valid = 1'b0;

    // Reference model: who owns the resource, for how many visible cycles,
    // whether the mandatory dead cycle is still pending, and the next start point.
    int   m_owner  = -1;
    int   m_held   = 0;
    int   m_ptr    = 0;
    int   m_grants = 0;
    bit   m_cool   = 1'b0;
    bit   m_pre    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    task automatic model_step(input bit r, input bit e, input logic [15:0] q);
        exp_t x;
        bit   others;
        m_pre = 1'b0;
        if (!r) begin
            m_owner = -1;
            m_held  = 0;
            m_ptr   = 0;
            m_cool  = 1'b0;
        end else if (m_owner >= 0) begin
            others = (q & ~(16'(1) << m_owner)) != 16'h0;
            if (!e || !q[m_owner]) begin
                m_owner = -1;
                m_cool  = 1'b1;
            end else if (m_held >= MH && others) begin
                m_owner = -1;
                m_cool  = 1'b1;
                m_pre   = 1'b1;
            end else begin
                m_held++;
            end
        end else if (m_cool) begin
            m_cool = 1'b0;
        end else if (e && q != 16'h0) begin
            for (int k = 0; k < N; k++) begin
                int i = (m_ptr + k) % N;
                if (q[i]) begin
                    m_owner = i;
                    m_held  = 1;
                    m_ptr   = (i + 1) % N;
                    m_grants++;
                    break;
                end
            end
        end
        x.grant = (m_owner >= 0) ? (16'(1) << m_owner) : 16'h0;
        x.idx   = (m_owner >= 0) ? 4'(m_owner) : 4'h0;
        x.valid = (m_owner >= 0);
        x.pre   = m_pre;
        exp_q.push_back(x);
    endtask

    task automatic drive(input bit r, input bit e, input logic [15:0] q);
        @(negedge clk);
        rst_n = r;
        en    = e;
        req   = q;
        model_step(r, e, q);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic begin_scenario();
        repeat (2) drive(1'b0, 1'b1, 16'h0);
        seen_q.delete();
        dut_pre_cnt = 0;
    endtask

    task automatic check_seen(input string name, input int el[$]);
        check({name, "_grant_count"}, seen_q.size(), el.size());
        for (int k = 0; k < el.size() && k < seen_q.size(); k++) begin
            check({name, "_grant_idx"}, seen_q[k], el[k]);
        end
    endtask

    // Monitor: pops one expectation per clock and records each new grant.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check("grant", grant, x.grant);
                check("grant_idx", grant_idx, x.idx);
                check("grant_valid", grant_valid, x.valid);
                check("preempt", preempt, x.pre);
                if (grant_valid && !prev_valid) seen_q.push_back(int'(grant_idx));
                if (preempt) dut_pre_cnt++;
                prev_valid = grant_valid;
            end
        end
    end

    initial begin
        int          el[$];
        logic [15:0] q;
        int          g0;
        int          budget;

        rst_n = 1'b0;
        en    = 1'b0;
        req   = 16'h0;

        // Two requesters, lower one served first, then the other after the gap.
        begin_scenario();
        repeat (2) drive(1'b1, 1'b1, 16'h0021);
        repeat (6) drive(1'b1, 1'b1, 16'h0020);
        repeat (3) drive(1'b1, 1'b1, 16'h0000);
        settle();
        el = {0, 5};
        check_seen("two_req", el);

        // All request; each drops after 3 granted cycles; full rotation plus wrap.
        begin_scenario();
        q      = 16'hFFFF;
        g0     = m_grants;
        budget = 0;
        while (m_grants - g0 < 17 && budget < 200) begin
            if (m_owner >= 0 && m_held >= 3) q[m_owner] = 1'b0;
            if (q == 16'h0 && m_owner < 0) q = 16'hFFFF;
            drive(1'b1, 1'b1, q);
            budget++;
        end
        repeat (3) drive(1'b1, 1'b1, 16'h0000);
        settle();
        el.delete();
        for (int i = 0; i < 16; i++) el.push_back(i);
        el.push_back(0);
        check_seen("rotation", el);

        // Two persistent requesters: hold limit forces alternation with preempt.
        begin_scenario();
        repeat (30) drive(1'b1, 1'b1, 16'h0003);
        repeat (3) drive(1'b1, 1'b1, 16'h0000);
        settle();
        el = {0, 1, 0};
        check_seen("hold_limit", el);
        check("hold_limit_preempts", dut_pre_cnt, 3);

        // Lone requester 15 holds indefinitely; pointer then wraps to 0.
        begin_scenario();
        repeat (50) drive(1'b1, 1'b1, 16'h8000);
        repeat (3) drive(1'b1, 1'b1, 16'h0000);
        repeat (4) drive(1'b1, 1'b1, 16'h8001);
        repeat (3) drive(1'b1, 1'b1, 16'h0000);
        settle();
        el = {15, 0};
        check_seen("lone_15", el);
        check("lone_15_preempts", dut_pre_cnt, 0);

        // Release coinciding with hold expiry, then en=0 mid-grant.
        begin_scenario();
        budget = 0;
        while (!(m_owner == 0 && m_held == MH) && budget < 20) begin
            drive(1'b1, 1'b1, 16'h0003);
            budget++;
        end
        drive(1'b1, 1'b1, 16'h0002);
        budget = 0;
        while (!(m_owner == 1 && m_held == 3) && budget < 20) begin
            drive(1'b1, 1'b1, 16'h0002);
            budget++;
        end
        repeat (3) drive(1'b1, 1'b0, 16'h0003);
        repeat (3) drive(1'b1, 1'b1, 16'h0003);
        repeat (3) drive(1'b1, 1'b1, 16'h0000);
        settle();
        el = {0, 1, 0};
        check_seen("release_vs_expiry", el);
        check("release_vs_expiry_preempts", dut_pre_cnt, 0);

        // Reset mid-grant drops the grant and restarts the pointer at 0.
        begin_scenario();
        repeat (4) drive(1'b1, 1'b1, 16'h0400);
        drive(1'b0, 1'b1, 16'h0400);
        repeat (3) drive(1'b1, 1'b1, 16'h0C00);
        repeat (3) drive(1'b1, 1'b1, 16'h0000);
        settle();
        el = {10, 10};
        check_seen("reset_mid_grant", el);

        // Randomized traffic with sparse toggling, occasional disable and reset.
        begin_scenario();
        q = 16'h0;
        for (int c = 0; c < 1500; c++) begin
            q = q ^ 16'($urandom & $urandom & $urandom);
            drive(($urandom_range(0, 299) != 0), ($urandom_range(0, 19) != 0), q);
        end
        repeat (4) drive(1'b1, 1'b1, 16'h0000);
        settle();

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
